tt_sweep_checker: RTL and testbench

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

---
 rtl/tt_sweep_pkg.sv | 14 +
 rtl/tt_sweep_checker_settle.sv | 42 ++++
 rtl/tt_sweep_checker.sv | 158 +++++++++++++++
 tb/tb_tt_sweep_checker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep checker: FSM encoding and widths.
package tt_sweep_pkg;

  localparam int unsigned VEC_COUNT = 16;  // vectors per sweep (4 inputs)
  localparam int unsigned IDX_W     = 4;   // vector index width
  localparam int unsigned CNT_W     = 5;   // mismatch count width (0..16)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tt_sweep_checker_settle.sv
// tt_settle_timer: counts down the hold time of one stimulus vector.
// Ports: clk, rst_n (sync, active-low), load (restart hold), en (count),
//        tick (registered; high in the last cycle of the hold).
module tt_settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Reload to SETTLE on every vector advance; tick marks the final hold cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(SETTLE);
    end else if (en && (cnt_q > CW'(1))) begin
      cnt_d = cnt_q - CW'(1);
    end
    tick_d = (cnt_d == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive 4-input equivalence sweep: drives {x,y,w,z} = 0..15, holds each
// vector SETTLE cycles, compares s1 against s2 on the last hold cycle.
// Ports: clk, rst_n (sync, active-low), start; x/y/w/z stimulus; s1/s2 results;
//        busy, done, pass, mismatch_cnt, first_fail_idx, fail_valid.
// Optional: define TT_SWEEP_FAILMAP_EN to add fail_map[15:0] (bit k = vector k failed).
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  output logic       w,
  output logic       z,
  input  logic       s1,
  input  logic       s2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] mismatch_cnt,
  output logic [3:0] first_fail_idx,
`ifdef TT_SWEEP_FAILMAP_EN
  output logic [15:0] fail_map,
`endif
  output logic       fail_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(VEC_COUNT);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic             fv_q, fv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
`ifdef TT_SWEEP_FAILMAP_EN
  logic [VEC_COUNT-1:0] map_q, map_d;
`endif
  logic             load_c;
  logic             tick;

  tt_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load_c),
    .en   (state_q == RUN),
    .tick (tick)
  );

  // Next-state, vector index and result accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ffi_d   = ffi_q;
    fv_d    = fv_q;
    pass_d  = pass_q;
`ifdef TT_SWEEP_FAILMAP_EN
    map_d   = map_q;
`endif
    load_c  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = '0;
          ffi_d   = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
`ifdef TT_SWEEP_FAILMAP_EN
          map_d   = '0;
`endif
          load_c  = 1'b1;
        end
      end
      RUN: begin
        // start is deliberately ignored here
        if (tick) begin
          if (s1 != s2) begin
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (!fv_q) begin
              ffi_d = idx_q;
            end
            fv_d = 1'b1;
`ifdef TT_SWEEP_FAILMAP_EN
            map_d[idx_q] = 1'b1;
`endif
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            pass_d  = (cnt_d == '0);
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            load_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ffi_q   <= '0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef TT_SWEEP_FAILMAP_EN
      map_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ffi_q   <= ffi_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef TT_SWEEP_FAILMAP_EN
      map_q   <= map_d;
`endif
    end
  end

  // The index register doubles as the stimulus register; x is the MSB.
  assign x              = idx_q[3];
  assign y              = idx_q[2];
  assign w              = idx_q[1];
  assign z              = idx_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_cnt   = cnt_q;
  assign first_fail_idx = ffi_q;
  assign fail_valid     = fv_q;
`ifdef TT_SWEEP_FAILMAP_EN
  assign fail_map       = map_q;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: two checkers (SETTLE=1 and SETTLE=3) driving a small
// combinational function; expected sweep results are queued at start and
// compared when done rises.
module tb_tt_sweep_checker;

  typedef struct {
    logic [4:0]  cnt;
    logic [3:0]  ffi;
    logic        fv;
    logic        pass;
    logic [15:0] map;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int t0 = 0;
  int mode1 = 0;
  int mode3 = 0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  logic x1, y1, w1, z1, s1_1, s2_1, busy1, done1, pass1, fv1;
  logic [4:0] cnt1;
  logic [3:0] ffi1;
  logic x3, y3, w3, z3, s1_3, s2_3, busy3, done3, pass3, fv3;
  logic [4:0] cnt3;
  logic [3:0] ffi3;
  logic [15:0] map1, map3;
  logic [3:0] vec1, vec3;
  assign vec1 = {x1, y1, w1, z1};
  assign vec3 = {x3, y3, w3, z3};

  // Unsimplified and simplified forms of the same function.
  function automatic logic f_full(input logic [3:0] v);
    return (v[3] & v[2]) | (v[3] & ~v[2] & v[1]) | (~v[3] & v[1] & v[0]);
  endfunction
  function automatic logic f_simp(input logic [3:0] v);
    return (v[3] & (v[2] | v[1])) | (~v[3] & v[1] & v[0]);
  endfunction
  // Fault-injection pattern per mode.
  function automatic logic inj(input int mode, input int k);
    case (mode)
      1:       return (k == 5) || (k == 12);
      2:       return 1'b1;
      3:       return (k == 9);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    s1_1 = f_full(vec1);
    s2_1 = f_simp(vec1) ^ inj(mode1, int'(vec1));
    s1_3 = f_full(vec3);
    // mode 3 also glitches vector 6 on every hold cycle except the sampled one
    s2_3 = f_simp(vec3) ^ inj(mode3, int'(vec3)) ^
           ((mode3 == 3) && (vec3 == 4'd6) && (((cyc - t0) % 3) != 2));
  end

  tt_sweep_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x(x1), .y(y1), .w(w1), .z(z1), .s1(s1_1), .s2(s2_1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1),
    .first_fail_idx(ffi1),
`ifdef TT_SWEEP_FAILMAP_EN
    .fail_map(map1),
`endif
    .fail_valid(fv1)
  );

  tt_sweep_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .x(x3), .y(y3), .w(w3), .z(z3), .s1(s1_3), .s2(s2_3),
    .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(cnt3),
    .first_fail_idx(ffi3),
`ifdef TT_SWEEP_FAILMAP_EN
    .fail_map(map3),
`endif
    .fail_valid(fv3)
  );

`ifndef TT_SWEEP_FAILMAP_EN
  assign map1 = '0;
  assign map3 = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int mode, input int settle);
    exp_t e;
    e.cnt = '0; e.ffi = '0; e.fv = 1'b0; e.map = '0;
    for (int k = 0; k < 16; k++) begin
      if (f_full(4'(k)) != (f_simp(4'(k)) ^ inj(mode, k))) begin
        if (!e.fv) e.ffi = 4'(k);
        e.fv = 1'b1;
        e.cnt = e.cnt + 5'd1;
        e.map[k] = 1'b1;
      end
    end
    e.pass = (e.cnt == 5'd0);
    e.lat = 16 * settle;
    return e;
  endfunction

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic start_sweep(input int which, input int mode);
    if (which == 1) mode1 = mode; else mode3 = mode;
    sb.push_back(model(mode, (which == 1) ? 1 : 3));
    pulse_start(which);
  endtask

  task automatic finish_sweep(input int which, input string tag);
    exp_t e;
    bit seen = 0;
    int lat = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if ((which == 1) ? done1 : done3) begin
        seen = 1;
        lat = cyc - t0;
        break;
      end
    end
    if (!seen || sb.size() == 0) begin
      chk({tag, "_done_timeout"}, 32'(seen), 32'(1));
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    if (which == 1) begin
      chk({tag, "_cnt"}, 32'(cnt1), 32'(e.cnt));
      chk({tag, "_ffi"}, 32'(ffi1), 32'(e.ffi));
      chk({tag, "_fv"}, 32'(fv1), 32'(e.fv));
      chk({tag, "_pass"}, 32'(pass1), 32'(e.pass));
      chk({tag, "_busy"}, 32'(busy1), 32'(0));
      chk({tag, "_vec"}, 32'(vec1), 32'(15));
`ifdef TT_SWEEP_FAILMAP_EN
      chk({tag, "_map"}, 32'(map1), 32'(e.map));
`endif
    end else begin
      chk({tag, "_cnt"}, 32'(cnt3), 32'(e.cnt));
      chk({tag, "_ffi"}, 32'(ffi3), 32'(e.ffi));
      chk({tag, "_fv"}, 32'(fv3), 32'(e.fv));
      chk({tag, "_pass"}, 32'(pass3), 32'(e.pass));
      chk({tag, "_vec"}, 32'(vec3), 32'(15));
`ifdef TT_SWEEP_FAILMAP_EN
      chk({tag, "_map"}, 32'(map3), 32'(e.map));
`endif
    end
  endtask

  task automatic wait_vec1(input logic [3:0] v, input string tag);
    bit seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (vec1 == v && busy1) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_reach_vec"}, 32'(seen), 32'(1));
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, "_vec"}, 32'(vec1), 32'(0));
    chk({tag, "_flags"}, 32'({busy1, done1, pass1, fv1}), 32'(0));
    chk({tag, "_cnt"}, 32'(cnt1), 32'(0));
    chk({tag, "_ffi"}, 32'(ffi1), 32'(0));
    chk({tag, "_map"}, 32'(map1), 32'(0));
  endtask

  initial begin
    // Reset, with start asserted to show it has no effect.
    rst_n = 1'b0;
    start1 = 1'b1;
    start3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle1("reset1");
    chk("reset3_flags", 32'({busy3, done3, pass3, fv3, cnt3, ffi3, vec3}), 32'(0));
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    rst_n = 1'b1;

    // Equivalent forms: clean pass.
    start_sweep(1, 0);
    chk("run_busy", 32'(busy1), 32'(1));
    chk("run_vec0", 32'(vec1), 32'(0));
    finish_sweep(1, "equiv");
    chk("equiv_done", 32'(done1), 32'(1));

    // Two injected mismatches.
    start_sweep(1, 1);
    finish_sweep(1, "two_fail");
`ifdef TT_SWEEP_FAILMAP_EN
    chk("two_fail_map_lit", 32'(map1), 32'h1020);
`endif

    // Every vector mismatches: count reaches 16 without wrapping.
    start_sweep(1, 2);
    finish_sweep(1, "all_fail");
    chk("all_fail_cnt_lit", 32'(cnt1), 32'd16);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold_cnt", 32'(cnt1), 32'd16);
    chk("done_hold_vec", 32'(vec1), 32'd15);

    // Restart from DONE clears results on the next cycle.
    start_sweep(1, 0);
    chk("restart_done", 32'(done1), 32'(0));
    chk("restart_cnt", 32'(cnt1), 32'(0));
    chk("restart_fv", 32'(fv1), 32'(0));
    chk("restart_busy", 32'(busy1), 32'(1));
    finish_sweep(1, "restart");

    // start during RUN is ignored.
    start_sweep(1, 1);
    wait_vec1(4'd3, "ign");
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("ign_vec4", 32'(vec1), 32'(4));
    chk("ign_cnt", 32'(cnt1), 32'(0));
    finish_sweep(1, "ignore");

    // Reset mid-sweep while vector 7 is driven, then a full sweep.
    mode1 = 1;
    pulse_start(1);
    wait_vec1(4'd7, "mid");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_idle1("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_stay_idle", 32'({busy1, done1}), 32'(0));
    start_sweep(1, 1);
    finish_sweep(1, "after_rst");

    // SETTLE=3: only the last hold cycle of each vector counts.
    start_sweep(3, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("s3_hold_vec0", 32'(vec3), 32'(0));
    @(posedge clk);
    #1;
    chk("s3_vec1", 32'(vec3), 32'(1));
    finish_sweep(3, "settle3");
    chk("settle3_ffi_lit", 32'(ffi3), 32'd9);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
